// File: rtl/rdc_watermark.sv
// rdc_watermark: per-channel request duration counter with saturating counts,
// sticky/level violation flags, software clear and high-watermark readout.
// Ports:
//   clk_i, rstn_i (async active-low), enable_i, clear_i (sync pulse)
//   events_i[k]                 : monitored event of channel k
//   events_weights_i[k*W +: W]  : weight of channel k, 0 disables it
//   interruption_rdc_o          : OR of all channel flags
//   interruption_vector_rdc_o   : registered per-channel violation flags
//   watermark_o[k*W +: W]       : longest registered count of channel k
module rdc_watermark #(
  parameter int N_CORES       = 2,
  parameter int CORE_EVENTS   = 4,
  parameter int WEIGHTS_WIDTH = 8,
  parameter bit STICKY        = 1'b1
) (
  input  logic                                       clk_i,
  input  logic                                       rstn_i,
  input  logic                                       enable_i,
  input  logic                                       clear_i,
  input  logic [N_CORES*CORE_EVENTS-1:0]             events_i,
  input  logic [N_CORES*CORE_EVENTS*WEIGHTS_WIDTH-1:0] events_weights_i,
  output logic                                       interruption_rdc_o,
  output logic [N_CORES*CORE_EVENTS-1:0]             interruption_vector_rdc_o,
  output logic [N_CORES*CORE_EVENTS*WEIGHTS_WIDTH-1:0] watermark_o
);

  localparam int N = N_CORES * CORE_EVENTS;
  localparam int W = WEIGHTS_WIDTH;
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [N-1:0] r_flag;

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [W-1:0] w_weight;
    logic         w_active;
    logic         w_viol;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_wm;

    assign w_weight = events_weights_i[g*W +: W];
    assign w_active = enable_i && (w_weight != '0);
    // Compares the registered count, so the flag trails cnt by one edge.
    assign w_viol   = w_active && (r_cnt > w_weight);

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_cnt <= '0;
      end else if (!w_active || !events_i[g]) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    // Counters idle at zero when disabled, so max() holds the old value.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_wm <= '0;
      end else if (clear_i) begin
        r_wm <= '0;
      end else if (r_cnt > r_wm) begin
        r_wm <= r_cnt;
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_flag[g] <= 1'b0;
      end else if (clear_i) begin
        r_flag[g] <= 1'b0;
      end else if (STICKY) begin
        r_flag[g] <= r_flag[g] | w_viol;
      end else begin
        // w_viol already includes enable_i, forcing 0 while disabled.
        r_flag[g] <= w_viol;
      end
    end

    assign watermark_o[g*W +: W] = r_wm;
  end

  assign interruption_vector_rdc_o = r_flag;
  assign interruption_rdc_o        = |r_flag;

endmodule

// File: tb/tb_rdc_watermark.sv
// tb_rdc_watermark: directed bench for rdc_watermark, one sticky and one
// level-mode instance sharing the same stimulus.
module tb_rdc_watermark;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  ev = '0;
  logic [63:0] wt = '0;

  logic        irq_s, irq_l;
  logic [7:0]  vec_s, vec_l;
  logic [63:0] wm_s, wm_l;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  rdc_watermark #(.STICKY(1'b1)) u_s (
    .clk_i(clk), .rstn_i(rstn), .enable_i(en), .clear_i(clr),
    .events_i(ev), .events_weights_i(wt),
    .interruption_rdc_o(irq_s),
    .interruption_vector_rdc_o(vec_s),
    .watermark_o(wm_s)
  );

  rdc_watermark #(.STICKY(1'b0)) u_l (
    .clk_i(clk), .rstn_i(rstn), .enable_i(en), .clear_i(clr),
    .events_i(ev), .events_weights_i(wt),
    .interruption_rdc_o(irq_l),
    .interruption_vector_rdc_o(vec_l),
    .watermark_o(wm_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 rstn = 1'b0;
    #1;
    vecs++;
    if (vec_s !== 8'h00 || irq_s !== 1'b0 || wm_s !== 64'h0) begin
      errs++;
      $display("FAIL reset_sticky vec=%h irq=%b wm=%h want 0", vec_s, irq_s, wm_s);
    end
    vecs++;
    if (vec_l !== 8'h00 || irq_l !== 1'b0 || wm_l !== 64'h0) begin
      errs++;
      $display("FAIL reset_level vec=%h irq=%b wm=%h want 0", vec_l, irq_l, wm_l);
    end
    #15 rstn = 1'b1;
    wt[0*8 +: 8] = 8'd3;
    wt[1*8 +: 8] = 8'd5;
    wt[2*8 +: 8] = 8'd0;
    wt[3*8 +: 8] = 8'd2;
    en = 1'b1;
    tick();
  endtask

  task automatic pulse0();
    ev[0] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vecs++;
    if (vec_s[0] !== 1'b0) begin
      errs++;
      $display("FAIL viol_early flag0=%b want 0", vec_s[0]);
    end
    ev[0] = 1'b0;
    tick();
  endtask

  task automatic test_violation();
    pulse0();
    vecs++;
    if (vec_s[0] !== 1'b1 || irq_s !== 1'b1) begin
      errs++;
      $display("FAIL viol_set flag0=%b irq=%b want 1 1", vec_s[0], irq_s);
    end
    vecs++;
    if (wm_s[0 +: 8] !== 8'd4) begin
      errs++;
      $display("FAIL viol_wm0 got %0d want 4", wm_s[0 +: 8]);
    end
    vecs++;
    if (vec_l[0] !== 1'b1) begin
      errs++;
      $display("FAIL level_set flag0=%b want 1", vec_l[0]);
    end
    tick();
    tick();
    vecs++;
    if (vec_s[0] !== 1'b1) begin
      errs++;
      $display("FAIL viol_sticky flag0=%b want 1", vec_s[0]);
    end
    vecs++;
    if (vec_l[0] !== 1'b0 || irq_l !== 1'b0) begin
      errs++;
      $display("FAIL level_drop flag0=%b irq=%b want 0 0", vec_l[0], irq_l);
    end
  endtask

  task automatic test_no_violation();
    ev[1] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ev[1] = 1'b0;
    tick();
    tick();
    vecs++;
    if (vec_s !== 8'h01) begin
      errs++;
      $display("FAIL noviol_vec got %h want 01", vec_s);
    end
    vecs++;
    if (wm_s[8 +: 8] !== 8'd5) begin
      errs++;
      $display("FAIL noviol_wm1 got %0d want 5", wm_s[8 +: 8]);
    end
    ev[1] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ev[1] = 1'b0;
    tick();
    tick();
    vecs++;
    if (wm_s[8 +: 8] !== 8'd5) begin
      errs++;
      $display("FAIL short_wm1 got %0d want 5", wm_s[8 +: 8]);
    end
  endtask

  task automatic test_disabled_and_sat();
    ev[2] = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    ev[2] = 1'b0;
    tick();
    tick();
    vecs++;
    if (wm_s[16 +: 8] !== 8'd0 || vec_s[2] !== 1'b0) begin
      errs++;
      $display("FAIL zero_weight wm2=%0d flag2=%b want 0 0", wm_s[16 +: 8], vec_s[2]);
    end
    wt[2*8 +: 8] = 8'd255;
    ev[2] = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    ev[2] = 1'b0;
    tick();
    tick();
    vecs++;
    if (wm_s[16 +: 8] !== 8'd255 || vec_s[2] !== 1'b0) begin
      errs++;
      $display("FAIL saturate wm2=%0d flag2=%b want 255 0", wm_s[16 +: 8], vec_s[2]);
    end
    vecs++;
    if (vec_l[2] !== 1'b0) begin
      errs++;
      $display("FAIL saturate_level flag2=%b want 0", vec_l[2]);
    end
  endtask

  task automatic test_level_mode();
    logic exp;
    ev[3] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      if (e == 7) ev[3] = 1'b0;
      tick();
      exp = (e >= 4 && e <= 7);
      vecs++;
      if (vec_l[3] !== exp) begin
        errs++;
        $display("FAIL level_edge%0d flag3=%b want %b", e, vec_l[3], exp);
      end
    end
  endtask

  task automatic test_clear_vs_set();
    ev[3] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vecs++;
    if (vec_s[3] !== 1'b0 || wm_s[24 +: 8] !== 8'd0) begin
      errs++;
      $display("FAIL clear_wins flag3=%b wm3=%0d want 0 0", vec_s[3], wm_s[24 +: 8]);
    end
    tick();
    ev[3] = 1'b0;
    vecs++;
    if (vec_s[3] !== 1'b1 || wm_s[24 +: 8] !== 8'd4) begin
      errs++;
      $display("FAIL reset_after_clear flag3=%b wm3=%0d want 1 4", vec_s[3], wm_s[24 +: 8]);
    end
    tick();
    tick();
    vecs++;
    if (vec_s !== 8'h08 || wm_s[24 +: 8] !== 8'd5 || wm_s[0 +: 8] !== 8'd0) begin
      errs++;
      $display("FAIL post_clear vec=%h wm3=%0d wm0=%0d want 08 5 0",
               vec_s, wm_s[24 +: 8], wm_s[0 +: 8]);
    end
  endtask

  task automatic test_enable_hold();
    pulse0();
    tick();
    en = 1'b0;
    ev[0] = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    vecs++;
    if (vec_s !== 8'h09 || irq_s !== 1'b1) begin
      errs++;
      $display("FAIL hold_flags vec=%h irq=%b want 09 1", vec_s, irq_s);
    end
    vecs++;
    if (wm_s[0 +: 8] !== 8'd4 || wm_s[24 +: 8] !== 8'd5 || wm_s[8 +: 8] !== 8'd0) begin
      errs++;
      $display("FAIL hold_wm wm0=%0d wm3=%0d wm1=%0d want 4 5 0",
               wm_s[0 +: 8], wm_s[24 +: 8], wm_s[8 +: 8]);
    end
    vecs++;
    if (vec_l !== 8'h00 || irq_l !== 1'b0) begin
      errs++;
      $display("FAIL hold_level vec=%h irq=%b want 00 0", vec_l, irq_l);
    end
    ev[0] = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vecs++;
    if (vec_s !== 8'h00 || irq_s !== 1'b0 || wm_s !== 64'h0) begin
      errs++;
      $display("FAIL sw_clear vec=%h irq=%b wm=%h want 0", vec_s, irq_s, wm_s);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    ev[0] = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    vecs++;
    if (vec_s[0] !== 1'b1 || wm_s[0 +: 8] !== 8'd6) begin
      errs++;
      $display("FAIL pre_reset flag0=%b wm0=%0d want 1 6", vec_s[0], wm_s[0 +: 8]);
    end
    #2 rstn = 1'b0;
    #1;
    vecs++;
    if (vec_s !== 8'h00 || irq_s !== 1'b0 || wm_s !== 64'h0) begin
      errs++;
      $display("FAIL async_reset vec=%h irq=%b wm=%h want 0", vec_s, irq_s, wm_s);
    end
    #3 rstn = 1'b1;
    tick();
    tick();
    vecs++;
    if (wm_s[0 +: 8] !== 8'd1) begin
      errs++;
      $display("FAIL restart_wm0 got %0d want 1", wm_s[0 +: 8]);
    end
    tick();
    tick();
    vecs++;
    if (vec_s[0] !== 1'b0) begin
      errs++;
      $display("FAIL restart_early flag0=%b want 0", vec_s[0]);
    end
    tick();
    vecs++;
    if (vec_s[0] !== 1'b1) begin
      errs++;
      $display("FAIL restart_flag flag0=%b want 1", vec_s[0]);
    end
    ev[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_violation();
    test_no_violation();
    test_disabled_and_sat();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    test_level_mode();
    test_clear_vs_set();
    test_enable_hold();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
